ext_rom_responder: RTL

EXT_ROM_RESPONDER -- requirements
Module: ext_rom_responder

---
 rtl/mcu51_pkg.sv | 18 +
 rtl/ext_rom_responder_if.sv | 13 +
 rtl/ext_rom_responder_code_rom.sv | 34 +++
 rtl/ext_rom_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/mcu51_pkg.sv
// rtl/mcu51_pkg.sv - shared MCU51 constants: ClkU timing and external ROM responder defaults
package mcu51_pkg;

    // ClkU: one machine cycle is 12 oscillator periods with two ALE pulses
    localparam int CLKU_OSC_PER_MC = 12;
    localparam int CLKU_ALE_PER_MC = 2;

    localparam int          RD_LAT_DEF  = 2;
    localparam logic [15:0] INT_TOP_DEF = 16'h1000;
    localparam int          WCNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } rom_state_e;

endpackage

// File: rtl/ext_rom_responder_if.sv
// rtl/ext_rom_responder_if.sv - MCU51 external program bus (ALE/PSEN/EA/P0/P2)
interface ext_rom_responder_if;
    logic       ALE;
    logic       PSEN;
    logic       EA;
    logic [7:0] P0_in;
    logic [7:0] P2_in;
    logic [7:0] P0_out;
    logic       P0_oe;

    modport master (output ALE, PSEN, EA, P0_in, P2_in, input P0_out, P0_oe);
    modport slave  (input ALE, PSEN, EA, P0_in, P2_in, output P0_out, P0_oe);
endinterface

// File: rtl/ext_rom_responder_code_rom.sv
// rtl/ext_rom_responder_code_rom.sv - byte-wide code ROM with write port and registered read
module code_rom #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    input  logic          rd_oob,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    // Array is never reset so contents survive a responder reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge write and read return the old byte by nonblocking ordering
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 8'h00;
        end else if (rd_en) begin
            rdata <= rd_oob ? 8'hFF : mem[raddr];
        end
    end

endmodule

// File: rtl/ext_rom_responder.sv
// rtl/ext_rom_responder.sv - answers MCU51 external code fetches from a loadable ROM
module ext_rom_responder
    import mcu51_pkg::*;
#(
    parameter int          ROM_AW  = 12,
    parameter int          RD_LAT  = RD_LAT_DEF,
    parameter logic [15:0] INT_TOP = INT_TOP_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    ext_rom_responder_if.slave   bus,
    input  logic                 prog_we,
    input  logic [ROM_AW-1:0]    prog_addr,
    input  logic [7:0]           prog_data,
    output logic [15:0]          fetch_cnt
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT - 1);

    rom_state_e        state, state_d;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic [15:0]       addr_q;
    logic              psen_q;
    logic              rom_rd;
    logic              cnt_inc;
    logic              oe;
    logic [7:0]        data_q;
    logic              psen_fall;
    logic              int_hit;
    logic              addr_oob;

    assign psen_fall = psen_q && !bus.PSEN;
    assign int_hit   = bus.EA && (addr_q < INT_TOP);
    assign addr_oob  = (ROM_AW < 16) && ((addr_q >> ROM_AW) != 16'd0);

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        rom_rd  = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (psen_fall && !bus.ALE && !int_hit) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (bus.PSEN || bus.ALE) begin
                    state_d = IDLE;
                end else if (wcnt == WAIT_LAST) begin
                    state_d = DRIVE;
                    rom_rd  = 1'b1;
                end else begin
                    wcnt_d = wcnt + 1'b1;
                end
            end
            DRIVE: begin
                // A new ALE means the MCU moved on; the fetch is not counted
                if (bus.ALE) begin
                    state_d = IDLE;
                end else if (bus.PSEN) begin
                    state_d = IDLE;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wcnt      <= '0;
            addr_q    <= 16'h0000;
            psen_q    <= 1'b1;
            fetch_cnt <= 16'h0000;
        end else begin
            state  <= state_d;
            wcnt   <= wcnt_d;
            psen_q <= bus.PSEN;
            if (bus.ALE) begin
                addr_q <= {bus.P2_in, bus.P0_in};
            end
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
        end
    end

    code_rom #(.AW(ROM_AW)) u_rom (
        .clk    (clk),
        .reset  (reset),
        .we     (prog_we),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .rd_en  (rom_rd),
        .raddr  (addr_q[ROM_AW-1:0]),
        .rd_oob (addr_oob),
        .rdata  (data_q)
    );

    // Drive is released combinationally in the cycle PSEN rises
    assign oe         = (state == DRIVE) && !bus.PSEN;
    assign bus.P0_oe  = oe;
    assign bus.P0_out = oe ? data_q : 8'h00;

endmodule
